// File: rtl/sram_word_master.sv
`default_nettype none
// ============================================================================
// Module   : sram_word_master
// Purpose  : Bus-side initiator for a pair of 8-bit synchronous SRAM banks
//            (even bytes / odd bytes). Converts one 16-bit request into bank
//            strobes, splitting misaligned words over two bank cycles, and
//            returns a registered 16-bit response.
// Revision : 1.0 - initial release
// ============================================================================
module sram_word_master #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH:0]   req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_be,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [15:0]           rsp_rdata,
    output logic                  e_cs,
    output logic                  e_oe,
    output logic                  e_wr,
    output logic [ADDR_WIDTH-1:0] e_addr,
    output logic [7:0]            e_din,
    input  logic [7:0]            e_q,
    output logic                  o_cs,
    output logic                  o_oe,
    output logic                  o_wr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [7:0]            o_din,
    input  logic [7:0]            o_q
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC1 = 3'd1;
    localparam logic [2:0] S_ACC2 = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;

    // Latched request fields
    logic [ADDR_WIDTH-1:0] r_word;
    logic                  r_mis;
    logic                  r_we;
    logic [1:0]            r_be;
    logic [7:0]            r_wdata_hi;

    logic                  w_accept;
    logic                  w_need_second;
    logic [ADDR_WIDTH-1:0] w_req_word;
    logic [ADDR_WIDTH-1:0] w_req_word_p1;
    logic [ADDR_WIDTH-1:0] w_word_p1;

    // Next values of the registered bank strobes
    logic                  w_e_cs_nxt;
    logic                  w_o_cs_nxt;
    logic                  w_we_nxt;
    logic [ADDR_WIDTH-1:0] w_e_addr_nxt;
    logic [ADDR_WIDTH-1:0] w_o_addr_nxt;
    logic [7:0]            w_e_din_nxt;
    logic [7:0]            w_o_din_nxt;

    logic [15:0]           w_rdata_map;

    assign req_ready     = (r_state == S_IDLE);
    assign rsp_valid     = (r_state == S_RESP);
    assign w_accept      = req_valid & req_ready;
    assign w_req_word    = req_addr[ADDR_WIDTH:1];
    // Word + 1 wraps naturally at the bank address width
    assign w_req_word_p1 = w_req_word + ADDR_WIDTH'(1);
    assign w_word_p1     = r_word + ADDR_WIDTH'(1);
    // Only a misaligned request with both bytes enabled needs a second cycle
    assign w_need_second = r_mis & (r_be == 2'b11);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (req_be == 2'b00) ? S_RESP : S_ACC1;
                end
            end
            S_ACC1: begin
                if (w_need_second) begin
                    w_state_nxt = S_ACC2;
                end else begin
                    w_state_nxt = r_we ? S_RESP : S_CAP;
                end
            end
            S_ACC2:  w_state_nxt = r_we ? S_RESP : S_CAP;
            S_CAP:   w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: strobes to present on the banks during the next cycle
    always_comb begin
        w_e_cs_nxt   = 1'b0;
        w_o_cs_nxt   = 1'b0;
        w_we_nxt     = 1'b0;
        w_e_addr_nxt = e_addr;
        w_o_addr_nxt = o_addr;
        w_e_din_nxt  = e_din;
        w_o_din_nxt  = o_din;
        if ((r_state == S_IDLE) && w_accept) begin
            w_we_nxt = req_we;
            if (!req_addr[0]) begin
                // Aligned: both lanes in the same cycle at the same word
                w_e_cs_nxt   = req_be[0];
                w_o_cs_nxt   = req_be[1];
                w_e_addr_nxt = w_req_word;
                w_o_addr_nxt = w_req_word;
                w_e_din_nxt  = req_wdata[7:0];
                w_o_din_nxt  = req_wdata[15:8];
            end else if (req_be[0]) begin
                // Misaligned low byte lives in the odd bank at W
                w_o_cs_nxt   = 1'b1;
                w_o_addr_nxt = w_req_word;
                w_o_din_nxt  = req_wdata[7:0];
            end else if (req_be[1]) begin
                // Misaligned high byte only: even bank at W+1 straight away
                w_e_cs_nxt   = 1'b1;
                w_e_addr_nxt = w_req_word_p1;
                w_e_din_nxt  = req_wdata[15:8];
            end
        end else if ((r_state == S_ACC1) && w_need_second) begin
            w_we_nxt     = r_we;
            w_e_cs_nxt   = 1'b1;
            w_e_addr_nxt = w_word_p1;
            w_e_din_nxt  = r_wdata_hi;
        end
    end

    // Bank strobe registers; oe and wr are both qualified by cs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_cs   <= 1'b0;
            e_oe   <= 1'b0;
            e_wr   <= 1'b0;
            e_addr <= '0;
            e_din  <= '0;
            o_cs   <= 1'b0;
            o_oe   <= 1'b0;
            o_wr   <= 1'b0;
            o_addr <= '0;
            o_din  <= '0;
        end else begin
            e_cs   <= w_e_cs_nxt;
            e_oe   <= w_e_cs_nxt & ~w_we_nxt;
            e_wr   <= w_e_cs_nxt & w_we_nxt;
            e_addr <= w_e_addr_nxt;
            e_din  <= w_e_din_nxt;
            o_cs   <= w_o_cs_nxt;
            o_oe   <= w_o_cs_nxt & ~w_we_nxt;
            o_wr   <= w_o_cs_nxt & w_we_nxt;
            o_addr <= w_o_addr_nxt;
            o_din  <= w_o_din_nxt;
        end
    end

    // Latch the request fields needed after the accept cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word     <= '0;
            r_mis      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= 2'b00;
            r_wdata_hi <= '0;
        end else if (w_accept) begin
            r_word     <= w_req_word;
            r_mis      <= req_addr[0];
            r_we       <= req_we;
            r_be       <= req_be;
            r_wdata_hi <= req_wdata[15:8];
        end
    end

    // Lane map of bank read data; disabled lanes read as zero
    always_comb begin
        w_rdata_map = 16'h0000;
        if (r_mis) begin
            w_rdata_map[7:0]  = r_be[0] ? o_q : 8'h00;
            w_rdata_map[15:8] = r_be[1] ? e_q : 8'h00;
        end else begin
            w_rdata_map[7:0]  = r_be[0] ? e_q : 8'h00;
            w_rdata_map[15:8] = r_be[1] ? o_q : 8'h00;
        end
    end

    // Capture read data in CAP, when both banks hold their last read result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata <= 16'h0000;
        end else if (r_state == S_CAP) begin
            rsp_rdata <= w_rdata_map;
        end
    end

endmodule
`default_nettype wire
